// File: rtl/inta_vector_sequencer_pkg.sv
// Shared types and helpers for the interrupt-acknowledge sequencer.
// Pure declarations; no state, no latency.
package pic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_G1,
    S_P2,
    S_G2,
    S_P3
  } ack_state_t;

  localparam logic [7:0] CALL_OP = 8'hCD;
  localparam int         MAX_IRQ = 8;

  // One-hot of the lowest-index set bit (zero when nothing is set).
  function automatic logic [MAX_IRQ-1:0] isr_lowest_set(input logic [MAX_IRQ-1:0] isr);
    return isr & (~isr + {{(MAX_IRQ-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/inta_vector_sequencer_edge_detect.sv
// Registers INTA and flags its falling/rising edges combinationally against the registered copy.
// Pulses are valid in the same cycle the new INTA level is presented; no backpressure.
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inta,
  output logic o_fall,
  output logic o_rise
);

  logic r_inta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inta_q <= 1'b1;
    else        r_inta_q <= i_inta;
  end

  assign o_fall = r_inta_q & ~i_inta;
  assign o_rise = ~r_inta_q & i_inta;

endmodule

// File: rtl/inta_vector_sequencer.sv
// Interrupt-acknowledge pulse sequencer (8086: 2 pulses, 8080: 3 pulses) owning the ISR bits.
// Outputs are registered on the edge that first samples a new INTA level; INTA pacing is the only flow control.
module inta_vector_sequencer #(
  parameter int          NUM_IRQ = 8,
  parameter logic [7:0]  CALL_OP = pic_pkg::CALL_OP,
  localparam int         LVL_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INTA,
  input  logic               irqValid,
  input  logic [LVL_W-1:0]   highestPriority,
  input  logic [7:0]         vectorBase,
  input  logic [7:0]         addrLow,
  input  logic [7:0]         addrHigh,
  input  logic               mode8086,
  input  logic               autoEoi,
  input  logic               eoiStrobe,
  input  logic               eoiSpecific,
  input  logic [LVL_W-1:0]   eoiLevel,
  output logic [7:0]         dataOut,
  output logic               dataOutEn,
  output logic [NUM_IRQ-1:0] irrClear,
  output logic [NUM_IRQ-1:0] inService,
  output logic               ackDone
);

  import pic_pkg::*;

  localparam logic [NUM_IRQ-1:0] LSB_ONE  = {{(NUM_IRQ-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]   LVL_LAST = LVL_W'(NUM_IRQ-1);

  logic                 w_fall, w_rise;
  ack_state_t           r_state, w_state_nxt;
  logic [LVL_W-1:0]     r_lvl;
  logic                 r_mode, r_spur;
  logic [7-LVL_W:0]     r_vbase_hi;
  logic [5-LVL_W:0]     r_alow_hi;
  logic [7:0]           r_ahigh;
  logic [7:0]           r_data;
  logic                 r_data_en;
  logic [NUM_IRQ-1:0]   r_irr_clr, r_isr;
  logic                 r_ack;

  logic                 w_enter_p1, w_final_rise, w_mode_eff;
  logic [7:0]           w_data_nxt;
  logic                 w_en_nxt;
  logic [MAX_IRQ-1:0]   w_isr_ext, w_lowest;
  logic [NUM_IRQ-1:0]   w_set, w_eoi_clr, w_auto_clr;
  logic                 w_unused_base_bits;

  inta_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inta (INTA),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  assign w_enter_p1   = (r_state == S_IDLE) & w_fall;
  assign w_final_rise = w_rise & (((r_state == S_P2) & r_mode) | (r_state == S_P3));
  assign w_mode_eff   = w_enter_p1 ? mode8086 : r_mode;

  // Level-index bits of the bases are replaced by the level itself.
  assign w_unused_base_bits = ^{vectorBase[LVL_W-1:0], addrLow[LVL_W+1:0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_P1;
      S_P1:    if (w_rise) w_state_nxt = S_G1;
      S_G1:    if (w_fall) w_state_nxt = S_P2;
      S_P2:    if (w_rise) w_state_nxt = r_mode ? S_IDLE : S_G2;
      S_G2:    if (w_fall) w_state_nxt = S_P3;
      S_P3:    if (w_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_nxt = 8'h00;
    w_en_nxt   = 1'b0;
    case (w_state_nxt)
      S_P1: if (!w_mode_eff) begin
        w_data_nxt = CALL_OP;
        w_en_nxt   = 1'b1;
      end
      S_P2: begin
        w_en_nxt   = 1'b1;
        w_data_nxt = r_mode ? {r_vbase_hi, r_lvl} : {r_alow_hi, r_lvl, 2'b00};
      end
      S_P3: begin
        w_en_nxt   = 1'b1;
        w_data_nxt = r_ahigh;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_isr_ext                = '0;
    w_isr_ext[NUM_IRQ-1:0]   = r_isr;
  end
  assign w_lowest = isr_lowest_set(w_isr_ext);

  // Clears are resolved before the P1 set so a same-bit collision keeps the bit.
  assign w_set      = (w_enter_p1 & irqValid) ? (LSB_ONE << highestPriority) : '0;
  assign w_eoi_clr  = !eoiStrobe ? '0 :
                      eoiSpecific ? (LSB_ONE << eoiLevel) : w_lowest[NUM_IRQ-1:0];
  assign w_auto_clr = (w_final_rise & autoEoi & ~r_spur) ? (LSB_ONE << r_lvl) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl      <= '0;
      r_mode     <= 1'b0;
      r_spur     <= 1'b0;
      r_vbase_hi <= '0;
      r_alow_hi  <= '0;
      r_ahigh    <= 8'h00;
      r_data     <= 8'h00;
      r_data_en  <= 1'b0;
      r_irr_clr  <= '0;
      r_isr      <= '0;
      r_ack      <= 1'b0;
    end else begin
      if (w_enter_p1) begin
        r_lvl      <= irqValid ? highestPriority : LVL_LAST;
        r_mode     <= mode8086;
        r_spur     <= ~irqValid;
        r_vbase_hi <= vectorBase[7:LVL_W];
        r_alow_hi  <= addrLow[7:LVL_W+2];
        r_ahigh    <= addrHigh;
      end
      r_data    <= w_data_nxt;
      r_data_en <= w_en_nxt;
      r_irr_clr <= w_set;
      r_isr     <= (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_set;
      r_ack     <= w_final_rise;
    end
  end

  assign dataOut   = r_data;
  assign dataOutEn = r_data_en;
  assign irrClear  = r_irr_clr;
  assign inService = r_isr;
  assign ackDone   = r_ack;

endmodule

// File: tb/tb_inta_vector_sequencer.sv
// Directed plus randomized acknowledge sequences against an arithmetic reference model of the ISR and bus bytes.
module tb_inta_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       INTA;
  logic       irqValid;
  logic [2:0] highestPriority;
  logic [7:0] vectorBase, addrLow, addrHigh;
  logic       mode8086, autoEoi, eoiStrobe, eoiSpecific;
  logic [2:0] eoiLevel;
  logic [7:0] dataOut;
  logic       dataOutEn;
  logic [7:0] irrClear, inService;
  logic       ackDone;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_isr;

  inta_vector_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .INTA            (INTA),
    .irqValid        (irqValid),
    .highestPriority (highestPriority),
    .vectorBase      (vectorBase),
    .addrLow         (addrLow),
    .addrHigh        (addrHigh),
    .mode8086        (mode8086),
    .autoEoi         (autoEoi),
    .eoiStrobe       (eoiStrobe),
    .eoiSpecific     (eoiSpecific),
    .eoiLevel        (eoiLevel),
    .dataOut         (dataOut),
    .dataOutEn       (dataOutEn),
    .irrClear        (irrClear),
    .inService       (inService),
    .ackDone         (ackDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] eoi_mask(input logic [7:0] isr, input bit spec, input int lvl);
    logic [7:0] m;
    m = 8'h00;
    if (spec) m = 8'h01 << lvl;
    else begin
      for (int i = 7; i >= 0; i--)
        if (isr[i]) m = 8'h01 << i;
    end
    return m;
  endfunction

  task automatic eoi(input bit spec, input logic [2:0] lvl);
    logic [7:0] clr;
    eoiStrobe = 1'b1; eoiSpecific = spec; eoiLevel = lvl;
    tick();
    eoiStrobe = 1'b0;
    clr   = eoi_mask(m_isr, spec, lvl);
    m_isr = m_isr & ~clr;
    chk("eoi_isr", inService, m_isr);
  endtask

  task automatic run_ack(input bit m, input bit valid, input logic [2:0] lvl, input bit aut,
                         input bit e_p1, input bit e_fin, input bit e_spec, input logic [2:0] e_lvl);
    logic [7:0] vb, al, ah, exp_b, clr, setb;
    int L;
    vb = vectorBase; al = addrLow; ah = addrHigh;
    L  = valid ? int'(lvl) : 7;
    mode8086 = m; irqValid = valid; highestPriority = lvl; autoEoi = aut;
    eoiStrobe = e_p1; eoiSpecific = e_spec; eoiLevel = e_lvl;
    INTA = 1'b0;
    tick();
    clr   = e_p1 ? eoi_mask(m_isr, e_spec, e_lvl) : 8'h00;
    setb  = valid ? (8'h01 << L) : 8'h00;
    m_isr = (m_isr & ~clr) | setb;
    chk("p1_irr", irrClear, setb);
    chk("p1_isr", inService, m_isr);
    chk("p1_en", dataOutEn, !m);
    chk("p1_dat", dataOut, m ? 8'h00 : 8'hCD);
    // Scramble everything that should have been captured at P1 entry.
    eoiStrobe = 1'b0; mode8086 = !m; irqValid = 1'($urandom);
    vectorBase = 8'($urandom); addrLow = 8'($urandom); addrHigh = 8'($urandom);
    tick();
    chk("p1_hold_irr", irrClear, 0);
    chk("p1_hold_en", dataOutEn, !m);
    INTA = 1'b1;
    tick();
    chk("g1_en", dataOutEn, 0);
    chk("g1_dat", dataOut, 0);
    chk("g1_ack", ackDone, 0);
    INTA = 1'b0;
    tick();
    exp_b = m ? 8'((vb & 8'hF8) + L) : 8'((al & 8'hE0) + L * 4);
    chk("p2_en", dataOutEn, 1);
    chk("p2_dat", dataOut, exp_b);
    if (!m) begin
      INTA = 1'b1;
      tick();
      chk("g2_en", dataOutEn, 0);
      chk("g2_ack", ackDone, 0);
      INTA = 1'b0;
      tick();
      chk("p3_en", dataOutEn, 1);
      chk("p3_dat", dataOut, ah);
    end
    eoiStrobe = e_fin; eoiSpecific = e_spec; eoiLevel = e_lvl;
    INTA = 1'b1;
    tick();
    clr = ((aut && valid) ? (8'h01 << L) : 8'h00) | (e_fin ? eoi_mask(m_isr, e_spec, e_lvl) : 8'h00);
    m_isr = m_isr & ~clr;
    chk("fin_ack", ackDone, 1);
    chk("fin_isr", inService, m_isr);
    chk("fin_en", dataOutEn, 0);
    eoiStrobe = 1'b0;
    tick();
    chk("ack_off", ackDone, 0);
  endtask

  initial begin
    rst_n = 1'b0; INTA = 1'b1; irqValid = 1'b0; highestPriority = 3'd0;
    vectorBase = 8'h00; addrLow = 8'h00; addrHigh = 8'h00;
    mode8086 = 1'b1; autoEoi = 1'b0; eoiStrobe = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0;
    m_isr = 8'h00;
    #23;
    chk("rst_dat", dataOut, 0);
    chk("rst_en", dataOutEn, 0);
    chk("rst_irr", irrClear, 0);
    chk("rst_isr", inService, 0);
    chk("rst_ack", ackDone, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 8086, base 0x20, level 2 -> vector 0x22
    vectorBase = 8'h20;
    run_ack(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t1_isr", inService, 8'h04);
    eoi(1'b1, 3'd2);

    // auto EOI, level 0
    run_ack(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t3_isr", inService, 8'h00);

    // 8080, level 5 -> CD F4 12
    addrLow = 8'hE0; addrHigh = 8'h12;
    run_ack(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t2_isr", inService, 8'h20);
    eoi(1'b0, 3'd0);

    // non-specific then specific EOI from 0x0A
    run_ack(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    run_ack(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t4_pre", inService, 8'h0A);
    eoi(1'b0, 3'd0);
    chk("t4_ns", inService, 8'h08);
    eoi(1'b1, 3'd3);
    chk("t4_sp", inService, 8'h00);
    eoi(1'b0, 3'd0);

    // spurious acknowledge, base 0x40 -> 0x47
    vectorBase = 8'h40;
    run_ack(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t5_isr", inService, 8'h00);

    // same-bit EOI at P1 entry: set wins; auto clear plus EOI at final rise: union
    run_ack(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    run_ack(1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
    run_ack(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);

    // reset during G1 of an 8080 sequence
    mode8086 = 1'b0; irqValid = 1'b1; highestPriority = 3'd4; autoEoi = 1'b0;
    INTA = 1'b0; tick();
    INTA = 1'b1; tick();
    rst_n = 1'b0;
    #2;
    m_isr = 8'h00;
    chk("t6_isr", inService, 0);
    chk("t6_en", dataOutEn, 0);
    chk("t6_dat", dataOut, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_ack", ackDone, 0);
    addrLow = 8'h60; addrHigh = 8'hA5;
    run_ack(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    for (int it = 0; it < 24; it++) begin
      vectorBase = 8'($urandom); addrLow = 8'($urandom); addrHigh = 8'($urandom);
      run_ack(1'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 2) == 0) eoi(1'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
